// File: rtl/lcd_bus_driver.sv
// rtl/lcd_bus_driver.sv - HD44780 bus cycle generator fed by the io_lcd register
// Turns strobed register writes into timed setup/enable/hold cycles followed by an execution wait.
module lcd_bus_driver #(
    parameter int SETUP_CYC     = 2,
    parameter int PULSE_CYC     = 12,
    parameter int HOLD_CYC      = 2,
    parameter int EXEC_CYC      = 2000,
    parameter int LONG_EXEC_CYC = 80000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] lcd_word_i,
    output logic        lcd_on_o,
    output logic        lcd_en_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic [7:0]  lcd_data_o,
    output logic        busy_o,
    output logic        ovf_o
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max2(max2(max2(SETUP_CYC, PULSE_CYC), max2(HOLD_CYC, EXEC_CYC)),
                                  LONG_EXEC_CYC);
    localparam int CW = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] EXEC_LOAD  = CW'(EXEC_CYC - 1);
    localparam logic [CW-1:0] LONG_LOAD  = CW'(LONG_EXEC_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            strobe_q;
    logic            pend_valid;
    logic            pend_rs;
    logic            pend_rw;
    logic [7:0]      pend_data;

    logic            word_strobe;
    logic            word_rs;
    logic            word_rw;
    logic [7:0]      word_data;
    logic            rise;
    logic            last;
    logic            dispatch;
    logic            is_long;
    logic            unused_bits;

    assign word_strobe = lcd_word_i[10];
    assign word_rs     = lcd_word_i[9];
    assign word_rw     = lcd_word_i[8];
    assign word_data   = lcd_word_i[7:0];
    assign unused_bits = ^lcd_word_i[30:11];

    assign rise = word_strobe & ~strobe_q;
    assign last = (cnt == '0);

    // Reads skip the execution wait, so their final HOLD cycle is the hand-off point.
    assign dispatch = last && ((state == S_WAIT) || ((state == S_HOLD) && lcd_rw_o));

    // Clear display and return home need the long execution time.
    assign is_long = !lcd_rs_o && !lcd_rw_o && (lcd_data_o inside {8'h01, 8'h02, 8'h03});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            cnt        <= '0;
            strobe_q   <= 1'b1;
            pend_valid <= 1'b0;
            pend_rs    <= 1'b0;
            pend_rw    <= 1'b0;
            pend_data  <= 8'h00;
            lcd_on_o   <= 1'b0;
            lcd_en_o   <= 1'b0;
            lcd_rs_o   <= 1'b0;
            lcd_rw_o   <= 1'b0;
            lcd_data_o <= 8'h00;
            busy_o     <= 1'b0;
            ovf_o      <= 1'b0;
        end else begin
            strobe_q <= word_strobe;
            lcd_on_o <= lcd_word_i[31];

            if ((state != S_IDLE) && !last) begin
                cnt <= cnt - CW'(1);
            end

            case (state)
                S_IDLE: begin
                    if (rise) begin
                        lcd_rs_o   <= word_rs;
                        lcd_rw_o   <= word_rw;
                        lcd_data_o <= word_data;
                        state      <= S_SETUP;
                        cnt        <= SETUP_LOAD;
                        busy_o     <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (last) begin
                        state    <= S_PULSE;
                        cnt      <= PULSE_LOAD;
                        lcd_en_o <= 1'b1;
                    end
                end
                S_PULSE: begin
                    if (last) begin
                        state    <= S_HOLD;
                        cnt      <= HOLD_LOAD;
                        lcd_en_o <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (last && !lcd_rw_o) begin
                        state <= S_WAIT;
                        cnt   <= is_long ? LONG_LOAD : EXEC_LOAD;
                    end
                end
                S_WAIT: begin
                end
                default: begin
                    state    <= S_IDLE;
                    lcd_en_o <= 1'b0;
                    busy_o   <= 1'b0;
                end
            endcase

            if (dispatch) begin
                if (pend_valid) begin
                    lcd_rs_o   <= pend_rs;
                    lcd_rw_o   <= pend_rw;
                    lcd_data_o <= pend_data;
                    state      <= S_SETUP;
                    cnt        <= SETUP_LOAD;
                    // A word arriving now refills the slot being vacated.
                    pend_valid <= rise;
                    if (rise) begin
                        pend_rs   <= word_rs;
                        pend_rw   <= word_rw;
                        pend_data <= word_data;
                    end
                end else if (rise) begin
                    lcd_rs_o   <= word_rs;
                    lcd_rw_o   <= word_rw;
                    lcd_data_o <= word_data;
                    state      <= S_SETUP;
                    cnt        <= SETUP_LOAD;
                end else begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
            end else if ((state != S_IDLE) && rise) begin
                if (!pend_valid) begin
                    pend_valid <= 1'b1;
                    pend_rs    <= word_rs;
                    pend_rw    <= word_rw;
                    pend_data  <= word_data;
                end else begin
                    ovf_o <= 1'b1;
                end
            end
        end
    end

endmodule
